// File: rtl/microtile_bist.sv
// Stimulus/response BIST engine for one microtile: drives tile_ui, folds tile_uo into a 16-bit MISR.
// Latency: each vector takes SETTLE_CYCLES+1 cycles; done rises NUM_VECTORS*(SETTLE_CYCLES+1) edges after start.
// Backpressure: none; start is ignored while busy, abort drops back to IDLE from SETTLE/CAPTURE.
module microtile_bist #(
    parameter int         NUM_VECTORS   = 256,
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        mode,
    input  logic [15:0] expected_sig,
    output logic [7:0]  tile_ui,
    input  logic [7:0]  tile_uo,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature
);

    localparam int IDX_W = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
    // An all-zero LFSR would lock up, so a zero seed is replaced.
    localparam logic [7:0]       SEED       = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       lfsr_q;
    logic [7:0]       lfsr_d;
    logic [15:0]      misr_q;
    logic [15:0]      misr_d;
    logic             mode_q;
    logic [7:0]       tile_ui_q;
    logic [7:0]       next_pat_d;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;

    // Next LFSR state, next MISR value and the pattern for the following vector.
    always_comb begin
        lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 8'hB8) : (lfsr_q >> 1);
        misr_d = {misr_q[14:0], 1'b0} ^ (misr_q[15] ? 16'h1021 : 16'h0000);
        misr_d = misr_d ^ {8'h00, tile_uo};
        idx_d  = idx_q + 1'b1;
        next_pat_d = mode_q ? lfsr_d : 8'(idx_d);
    end

    // Run-control FSM; all outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            lfsr_q    <= SEED;
            misr_q    <= 16'hFFFF;
            mode_q    <= 1'b0;
            tile_ui_q <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    // start beats abort here: abort only means something inside a run.
                    if (start) begin
                        idx_q     <= '0;
                        misr_q    <= 16'hFFFF;
                        lfsr_q    <= SEED;
                        mode_q    <= mode;
                        tile_ui_q <= mode ? SEED : 8'h00;
                        cnt_q     <= CNT_RELOAD;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        pass_q    <= 1'b0;
                        state_q   <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        tile_ui_q <= 8'h00;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b0;
                        pass_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end else if (cnt_q == '0) begin
                        state_q <= S_CAPTURE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_CAPTURE: begin
                    if (abort) begin
                        // Signature is left as-is so the partial result can be inspected.
                        tile_ui_q <= 8'h00;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b0;
                        pass_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end else begin
                        misr_q <= misr_d;
                        lfsr_q <= lfsr_d;
                        if (idx_q == LAST_IDX) begin
                            // Compare uses the post-step MISR so pass is valid with done.
                            tile_ui_q <= 8'h00;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            pass_q    <= (misr_d == expected_sig);
                            state_q   <= S_DONE;
                        end else begin
                            idx_q     <= idx_d;
                            tile_ui_q <= next_pat_d;
                            cnt_q     <= CNT_RELOAD;
                            state_q   <= S_SETTLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign tile_ui   = tile_ui_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = misr_q;

endmodule

// File: tb/tb_microtile_bist.sv
// Directed bench for microtile_bist with 4 vectors, 2 settle cycles, tile_uo looped back to tile_ui.
// Latency: checks every cycle of each run, done expected 12 edges after start.
// Backpressure: exercises start-while-busy, abort mid-run, abort+start and mid-run reset.
module tb_microtile_bist;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        mode;
    logic [15:0] expected_sig;
    logic [7:0]  tile_ui;
    logic [7:0]  tile_uo;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] signature;

    int n_checks = 0;
    int n_fail   = 0;

    microtile_bist #(
        .NUM_VECTORS  (4),
        .SETTLE_CYCLES(2),
        .LFSR_SEED    (8'hA5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .mode        (mode),
        .expected_sig(expected_sig),
        .tile_ui     (tile_ui),
        .tile_uo     (tile_uo),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .signature   (signature)
    );

    assign tile_uo = tile_ui;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_tile_ui"}, 32'(tile_ui), 32'h00);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
        check({tag, "_pass"}, 32'(pass), 32'h0);
        check({tag, "_sig"}, 32'(signature), 32'hFFFF);
    endtask

    // One full 4-vector run starting from IDLE or DONE; vecs holds vector 0 in the top byte.
    task automatic run_check(input string tag, input logic m, input logic [31:0] vecs,
                             input logic [15:0] exp_sig, input logic chk_sig,
                             input logic chk_pass, input logic exp_pass,
                             input logic pulse_mid, input logic abort_too);
        logic [7:0] v;
        @(negedge clk);
        start        = 1'b1;
        mode         = m;
        abort        = abort_too;
        expected_sig = exp_sig;
        for (int e = 0; e < 12; e++) begin
            @(negedge clk);
            if (e == 0) begin
                start = 1'b0;
                abort = 1'b0;
                mode  = ~m;
                check({tag, "_pass_cleared"}, 32'(pass), 32'h0);
            end
            if (pulse_mid && e == 4) start = 1'b1;
            if (e == 5) start = 1'b0;
            v = vecs[31 - 8 * (e / 3) -: 8];
            check($sformatf("%s_ui_e%0d", tag, e), 32'(tile_ui), 32'(v));
            check($sformatf("%s_busy_e%0d", tag, e), 32'(busy), 32'h1);
            check($sformatf("%s_done_e%0d", tag, e), 32'(done), 32'h0);
        end
        @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'h1);
        check({tag, "_busy_end"}, 32'(busy), 32'h0);
        check({tag, "_ui_end"}, 32'(tile_ui), 32'h00);
        if (chk_sig)  check({tag, "_sig"}, 32'(signature), 32'(exp_sig));
        if (chk_pass) check({tag, "_pass"}, 32'(pass), 32'(exp_pass));
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        mode         = 1'b0;
        expected_sig = 16'h0000;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;

        // Counter loopback, matching and mismatching golden signature
        run_check("cnt_pass", 1'b0, 32'h00010203, 16'h0E1C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        run_check("cnt_fail", 1'b0, 32'h00010203, 16'h0E1D, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("cnt_fail_sig", 32'(signature), 32'h0E1C);

        // LFSR sequence; mode is flipped after start to confirm it is latched
        run_check("lfsr", 1'b1, 32'hA5EA7582, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Abort during vector 2
        @(negedge clk);
        start = 1'b1;
        mode  = 1'b0;
        for (int e = 0; e < 7; e++) begin
            @(negedge clk);
            if (e == 0) start = 1'b0;
        end
        check("abort_pre_ui", 32'(tile_ui), 32'h02);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_ui", 32'(tile_ui), 32'h00);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        check("abort_sig_held", 32'(signature), 32'hCF9E);
        @(negedge clk);
        check("abort_idle_stays", 32'(busy), 32'h0);

        // Restart after abort reproduces the signature
        run_check("restart", 1'b0, 32'h00010203, 16'h0E1C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // Start pulsed during SETTLE must not disturb timing
        run_check("start_busy", 1'b0, 32'h00010203, 16'h0E1C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

        // Abort together with start in DONE: start wins
        run_check("abort_start", 1'b0, 32'h00010203, 16'h0E1C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);

        // Mid-run reset while in CAPTURE of vector 1
        @(negedge clk);
        start = 1'b1;
        mode  = 1'b0;
        for (int e = 0; e < 6; e++) begin
            @(negedge clk);
            if (e == 0) start = 1'b0;
        end
        check("midrst_pre_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        #2;
        rst_n = 1'b1;
        run_check("post_rst", 1'b0, 32'h00010203, 16'h0E1C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/microtile_bist.md
# microtile_bist

On-chip stimulus/response engine for one microtile. It drives the tile's 8-bit `ui_in` with a generated vector sequence and samples the tile's 8-bit `uo_out` after a settle window. All responses fold into a 16-bit signature register, which is compared against an expected value at the end of the run. It sits beside a tile in the collection and replaces the passive simulation harness with a self-checking hardware run.

## Interface
- `NUM_VECTORS`, 256: vectors per run; range 1..65536.
- `SETTLE_CYCLES`, 2: cycles each vector is held before capture; must be ≥1.
- `LFSR_SEED`, 8'hA5: LFSR start state; a seed of 0 is replaced by 8'h01.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  level sampled each cycle; starts a run when in IDLE or DONE.
- `abort`  in  1  returns the block to IDLE from SETTLE or CAPTURE.
- `mode`  in  1  pattern source: 0 = binary counter, 1 = LFSR; sampled on the start edge only.
- `expected_sig`  in  16  golden signature; sampled on entry to DONE.
- `tile_ui`  out  8  registered drive to the tile's `ui_in`.
- `tile_uo`  in  8  the tile's `uo_out`, treated as synchronous to `clk`.
- `busy`  out  1  high in SETTLE and CAPTURE.
- `done`  out  1  high in DONE.
- `pass`  out  1  registered result of the compare; valid while `done`=1.
- `signature`  out  16  current MISR contents.

## Operation
- States: IDLE, SETTLE, CAPTURE, DONE.
- Reset values: state IDLE, `tile_ui`=0, `busy`=0, `done`=0, `pass`=0, `signature`=16'hFFFF, vector index 0, LFSR = seed.
- IDLE or DONE with `start`=1:
  - index ← 0, MISR ← 16'hFFFF, LFSR ← seed, mode latched.
  - `tile_ui` ← pattern(0); settle counter ← SETTLE_CYCLES-1; go to SETTLE.
  - `done` and `pass` clear.
- SETTLE: counter decrements each cycle; when it reads 0, go to CAPTURE. `tile_ui` is held.
- CAPTURE, one cycle:
  - MISR ← step(MISR, `tile_uo`).
  - If index = NUM_VECTORS-1: go to DONE and set `tile_ui` ← 0.
  - Otherwise: index++, `tile_ui` ← next pattern, reload the counter, go to SETTLE.
- DONE:
  - `done`=1; `pass` = (MISR == `expected_sig`), computed on the MISR value after the final step and registered on entry.
  - Hold until `start` or reset.
- Counter pattern: `tile_ui` = index[7:0]; wraps 255→0 when NUM_VECTORS > 256.
- LFSR pattern: Galois, right shift. next = lfsr[0] ? (lfsr>>1)^8'hB8 : lfsr>>1. The vector applied is the current state; the LFSR advances on each CAPTURE.
- MISR step: shifted = {m[14:0],1'b0}; if m[15], shifted ^= 16'h1021; next = shifted ^ {8'h00, tile_uo}.
- Boundary rules:
  - `start` while busy: ignored.
  - `abort` in SETTLE or CAPTURE: next state IDLE; `tile_ui`, `busy`, `done`, `pass` all return to 0; `signature` holds.
  - `abort` and `start` together in IDLE or DONE: `start` wins; `abort` has no effect outside a run.
  - `rst_n` low mid-run: immediate return to all reset values, with no partial `done`.

## Timing
- `start` sampled at edge E0 → `tile_ui` = vector 0 and `busy`=1 after E0.
- Each vector occupies SETTLE_CYCLES+1 cycles. `tile_uo` is sampled at the edge that ends CAPTURE, i.e. SETTLE_CYCLES+1 edges after `tile_ui` changed.
- `done` rises NUM_VECTORS×(SETTLE_CYCLES+1) edges after E0; `busy` falls on the same edge.
- `pass` is valid in the same cycle `done` rises.
- `signature` updates once per vector, only at the end of CAPTURE.

## Test plan
- Reset: hold `rst_n`=0 → `tile_ui`=0, `busy`=0, `done`=0, `pass`=0, `signature`=16'hFFFF.
- Counter loopback: NUM_VECTORS=4, SETTLE_CYCLES=2, `tile_uo`=`tile_ui`, `mode`=0.
  - `tile_ui` steps 00,01,02,03, each held 3 cycles.
  - `done` asserts 12 edges after start; `signature`=16'h0E1C.
  - `pass`=1 with `expected_sig`=16'h0E1C; `pass`=0 with 16'h0E1D.
- LFSR sequence: `mode`=1, seed 8'hA5 → `tile_ui` sequence A5, EA, 75, 82.
- Abort and restart:
  - Assert `abort` during vector 2 → IDLE next cycle, `tile_ui`=0, `done`=0.
  - A new `start` reproduces signature 16'h0E1C.
- Start while busy: pulse `start` during SETTLE → no restart; `done` time unchanged.
- Mid-run reset: drop `rst_n` in CAPTURE → outputs return to reset values immediately; a subsequent run completes normally.
